// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the memory stall controller and its wait counter.
package pipeline_ctrl_pkg;

  // Sequencer states for one data-memory access.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memState_e;

  // Default SRAM latency in cycles. The legal range is 1..15.
  localparam int WAIT_CYCLES_DFLT = 4;

  // Default SRAM word-address width.
  localparam int SRAM_ADDR_W_DFLT = 17;

  // Width of the latency counter. Four bits cover every legal latency.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_stall_controller_wait_counter.sv
// Latency counter for SRAM accesses. The terminal count marks the last
// cycle of an access.
module wait_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear takes priority over counting, so each access starts again from zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register. It is reset asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stall_controller.sv
// MEM-stage SRAM sequencer. It also generates the freeze and flush controls
// for the pipeline stage registers.
module mem_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int BIT_NUMBER  = 32,
  parameter int SRAM_ADDR_W = SRAM_ADDR_W_DFLT,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DFLT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [BIT_NUMBER-1:0]  address,
  input  logic [BIT_NUMBER-1:0]  wdata,
  input  logic                   hazard,
  input  logic                   branch_taken,
  input  logic [BIT_NUMBER-1:0]  sram_rdata,
  output logic                   sram_req,
  output logic                   sram_we,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [BIT_NUMBER-1:0]  sram_wdata,
  output logic [BIT_NUMBER-1:0]  rdata,
  output logic                   mem_ready,
  output logic                   freeze_all,
  output logic                   freeze_front,
  output logic                   flush
);

  memState_e              state_q, state_d;
  logic                   sramReq_q, sramReq_d;
  logic                   sramWe_q, sramWe_d;
  logic [SRAM_ADDR_W-1:0] sramAddr_q, sramAddr_d;
  logic [BIT_NUMBER-1:0]  sramWdata_q, sramWdata_d;
  logic [BIT_NUMBER-1:0]  rdata_q, rdata_d;

  logic req;
  logic waitDone;
  logic memBusy;
  logic unusedAddrBits;

  // Accesses are word accesses. The byte offset and the bits above the SRAM
  // range are not used.
  assign unusedAddrBits = ^{address[BIT_NUMBER-1:SRAM_ADDR_W+2], address[1:0]};

  assign req = mem_r_en | mem_w_en;

  wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clear_i(state_q != ACCESS),
    .en_i   (state_q == ACCESS),
    .tc_o   (waitDone)
  );

  // Next-state logic. The SRAM outputs are latched on entry to ACCESS and
  // released on the last ACCESS cycle. A load captures the read data on that
  // same cycle.
  always_comb begin
    state_d     = state_q;
    sramReq_d   = sramReq_q;
    sramWe_d    = sramWe_q;
    sramAddr_d  = sramAddr_q;
    sramWdata_d = sramWdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d     = ACCESS;
          sramReq_d   = 1'b1;
          sramWe_d    = mem_w_en;
          sramAddr_d  = address[SRAM_ADDR_W+1:2];
          sramWdata_d = wdata;
        end
      end
      ACCESS: begin
        if (waitDone) begin
          if (!sramWe_q) begin
            rdata_d = sram_rdata;
          end
          sramReq_d = 1'b0;
          sramWe_d  = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. An asynchronous reset aborts any access in
  // progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sramReq_q   <= 1'b0;
      sramWe_q    <= 1'b0;
      sramAddr_q  <= '0;
      sramWdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      sramReq_q   <= sramReq_d;
      sramWe_q    <= sramWe_d;
      sramAddr_q  <= sramAddr_d;
      sramWdata_q <= sramWdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Memory busy has the highest priority. A branch that arrives while memory
  // is busy is deferred until the pipeline is released.
  assign memBusy      = ((state_q == IDLE) && req) || (state_q == ACCESS);
  assign freeze_all   = memBusy;
  assign freeze_front = memBusy | hazard;
  assign flush        = branch_taken & ~memBusy;
  assign mem_ready    = (state_q == DONE);

  assign sram_req   = sramReq_q;
  assign sram_we    = sramWe_q;
  assign sram_addr  = sramAddr_q;
  assign sram_wdata = sramWdata_q;
  assign rdata      = rdata_q;

endmodule

// File: doc/mem_stall_controller.md
Name: mem_stall_controller

Overview:
- Sequences data-memory accesses from the MEM stage onto a fixed-latency, word-addressed SRAM.
- Generates the pipeline control for every stage register: freeze of all stages, front-end freeze for data hazards, and the IF/ID flush for taken branches.
- Sits between the EXE/MEM stage registers, the hazard unit and the external SRAM.
- Its freeze outputs drive the freeze inputs of the IF, ID, EXE and MEM stage registers.

Parameters:
- BIT_NUMBER, 32: CPU address and data width.
- SRAM_ADDR_W, 17: SRAM word-address width.
- WAIT_CYCLES, 4: SRAM access latency in cycles. Legal range is 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- mem_r_en  input  1  MEM-stage load request.
- mem_w_en  input  1  MEM-stage store request.
- address  input  BIT_NUMBER  byte address from the ALU result.
- wdata  input  BIT_NUMBER  store data.
- hazard  input  1  data-hazard stall from the hazard unit.
- branch_taken  input  1  taken-branch indication from EXE.
- sram_rdata  input  BIT_NUMBER  SRAM read data; valid in the last ACCESS cycle.
- sram_req  output  1  SRAM access strobe.
- sram_we  output  1  SRAM write enable.
- sram_addr  output  SRAM_ADDR_W  SRAM word address.
- sram_wdata  output  BIT_NUMBER  SRAM write data.
- rdata  output  BIT_NUMBER  load result to the WB stage register.
- mem_ready  output  1  access complete; pipeline may advance.
- freeze_all  output  1  freezes the IF, ID, EXE and MEM stage registers.
- freeze_front  output  1  freezes the PC and IF/ID; bubble into ID/EXE.
- flush  output  1  clears IF/ID and ID/EXE.

Behaviour:
- States are IDLE, ACCESS and DONE; the state is registered.
- Reset (rst=0), effective immediately and including mid-access:
  - state = IDLE, counter = 0.
  - sram_req, sram_we, sram_addr, sram_wdata, rdata, mem_ready all = 0.
- IDLE:
  - A request is req = mem_r_en | mem_w_en. If both enables are high, the write wins.
  - On req, the next edge latches sram_addr = address[SRAM_ADDR_W+1:2], sram_wdata = wdata and sram_we = mem_w_en, sets sram_req = 1 and counter = 0, and moves to ACCESS.
  - address[1:0] is ignored; all accesses are word accesses.
- ACCESS:
  - sram_req and the latched SRAM outputs are held stable.
  - The counter increments each cycle.
  - When counter == WAIT_CYCLES-1: for a read, rdata <= sram_rdata; then sram_req <= 0, sram_we <= 0, and the state moves to DONE.
  - Each access therefore spends exactly WAIT_CYCLES cycles in ACCESS.
- DONE:
  - mem_ready = 1 for exactly one cycle and freeze_all = 0, so the pipeline advances.
  - req is ignored in DONE, because the same instruction is still present in MEM during this cycle. The state returns to IDLE.
- Store data is never fed back: rdata holds its last load value across stores.
- rdata holds its value until the next load completes.
- Combinational control outputs:
  - mem_busy = (IDLE & req) | ACCESS.
  - freeze_all = mem_busy.
  - freeze_front = mem_busy | hazard.
  - flush = branch_taken & ~mem_busy.
- Priority is memory busy, then branch, then hazard:
  - A branch arriving during a memory freeze is deferred. branch_taken stays stable while EXE is frozen, so the flush asserts in the DONE cycle.
  - When flush and hazard coincide, both outputs assert. IF/ID clears regardless.
- Total latency per access:
  - From req first seen in IDLE to mem_ready is WAIT_CYCLES+1 cycles.
  - The instruction therefore occupies MEM for WAIT_CYCLES+2 cycles.
- Back-to-back accesses: after DONE there is at least one IDLE cycle. Under continuous requests, freeze_all is low only during DONE.
- Counter width is 4 bits. WAIT_CYCLES=1 gives a single ACCESS cycle.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - the state enum (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - the default WAIT_CYCLES;
  - the SRAM_ADDR_W constant.
- One sub-module is natural: wait_counter, a resettable 4-bit counter with an enable and a terminal-count output at WAIT_CYCLES-1.
- The FSM, the SRAM output latches and the control logic stay in the top module.

Test Plan:
- Reset: drive rst=0 mid-ACCESS with sram_req=1 -> all outputs read 0 and the state is IDLE in the same cycle. After release with no requests, freeze_all=0.
- Load with WAIT_CYCLES=4:
  - Stimulus: mem_r_en=1, address=0x0000_0410; sram_rdata=0xDEAD_BEEF in the last ACCESS cycle.
  - Expected: sram_addr=0x104 and sram_we=0; freeze_all high for 5 cycles; mem_ready high in cycle 6; rdata=0xDEAD_BEEF.
- Store:
  - Stimulus: mem_w_en=1, address=0x0000_0008, wdata=0x1234_5678.
  - Expected: sram_we=1, sram_addr=2, sram_wdata=0x1234_5678, each held for 4 cycles; rdata unchanged.
- Back-to-back: two consecutive loads -> exactly one DONE cycle, then one IDLE cycle with freeze_all=1, then a second ACCESS of 4 cycles.
- Branch during access: branch_taken=1 raised in the second ACCESS cycle -> flush=0 until DONE, flush=1 in DONE.
- Hazard: hazard=1 with no request -> freeze_front=1, freeze_all=0. Hazard=1 together with branch_taken=1 -> flush=1 and freeze_front=1.
